// File: rtl/vixen_muldiv_sched.sv
// Shared mul/div issue scheduler: round-robin grant across four threads, one issue per cycle,
// and a credit-managed writeback FIFO that always has room for every in-flight completion.
module vixen_muldiv_sched #(
    parameter int NUM_THREADS = 4,
    parameter int WB_DEPTH    = 4,
    parameter int UOP_W       = 64,
    parameter int ROB_W       = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_THREADS-1:0]       req_valid,
    output logic [NUM_THREADS-1:0]       req_ready,
    input  logic [NUM_THREADS-1:0]       req_is_div,
    input  logic [NUM_THREADS*UOP_W-1:0] req_uop,
    input  logic [NUM_THREADS*ROB_W-1:0] req_rob_id,
    output logic                         mul_issue_valid,
    output logic [UOP_W-1:0]             mul_issue_uop,
    output logic [ROB_W-1:0]             mul_issue_rob_id,
    output logic [1:0]                   mul_issue_thread_id,
    input  logic                         mul_complete,
    input  logic [UOP_W-1:0]             mul_result,
    input  logic [ROB_W-1:0]             mul_rob_id,
    input  logic [1:0]                   mul_thread_id,
    output logic                         div_issue_valid,
    output logic [UOP_W-1:0]             div_issue_uop,
    output logic [ROB_W-1:0]             div_issue_rob_id,
    output logic [1:0]                   div_issue_thread_id,
    input  logic                         div_complete,
    input  logic [UOP_W-1:0]             div_result,
    input  logic [ROB_W-1:0]             div_rob_id,
    input  logic [1:0]                   div_thread_id,
    output logic                         wb_valid,
    input  logic                         wb_ready,
    output logic [UOP_W-1:0]             wb_result,
    output logic [ROB_W-1:0]             wb_rob_id,
    output logic [1:0]                   wb_thread_id,
    output logic                         sched_busy
);

    localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = UOP_W + ROB_W + 2;

    logic [1:0]    rr_ptr_q;
    logic [CW-1:0] fifo_count_q, fifo_count_d;
    logic [CW-1:0] mul_inflight_q, mul_inflight_d;
    logic          div_inflight_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, div_wr_addr;
    logic [EW-1:0] fifo_mem [WB_DEPTH];

    logic [CW:0]   used;
    logic          credit_ok;
    logic [3:0]    eligible;
    logic [1:0]    gnt_idx, cand;
    logic          gnt_found, do_grant, gnt_is_div, mul_grant, div_grant;
    logic [UOP_W-1:0] gnt_uop;
    logic [ROB_W-1:0] gnt_rob;
    logic          mul_push, div_push, pop;
    logic [EW-1:0] head;

    // Every in-flight op already owns a FIFO slot, so completions can never be refused.
    assign used      = {1'b0, fifo_count_q} + {1'b0, mul_inflight_q} + {{CW{1'b0}}, div_inflight_q};
    assign credit_ok = used < (CW+1)'(WB_DEPTH);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            eligible[i] = req_valid[i] && credit_ok && (!req_is_div[i] || !div_inflight_q);
        end
    end

    always_comb begin
        gnt_idx   = rr_ptr_q;
        gnt_found = 1'b0;
        cand      = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!gnt_found && eligible[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign do_grant   = gnt_found && rst_n;
    assign req_ready  = do_grant ? (NUM_THREADS'(1) << gnt_idx) : '0;
    assign gnt_is_div = req_is_div[gnt_idx];
    assign gnt_uop    = req_uop[gnt_idx*UOP_W +: UOP_W];
    assign gnt_rob    = req_rob_id[gnt_idx*ROB_W +: ROB_W];
    assign mul_grant  = do_grant && !gnt_is_div;
    assign div_grant  = do_grant && gnt_is_div;

    // Completions with nothing in flight are stale results from before a reset.
    assign mul_push = mul_complete && (mul_inflight_q != '0);
    assign div_push = div_complete && div_inflight_q;
    assign wb_valid = fifo_count_q != '0;
    assign pop      = wb_valid && wb_ready;

    always_comb begin
        mul_inflight_d = mul_inflight_q + CW'(mul_grant) - CW'(mul_push);
        fifo_count_d   = fifo_count_q + CW'(mul_push) + CW'(div_push) - CW'(pop);
        wr_ptr_d       = wr_ptr_q + PW'(mul_push) + PW'(div_push);
        rd_ptr_d       = rd_ptr_q + PW'(pop);
        div_wr_addr    = mul_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q            <= '0;
            fifo_count_q        <= '0;
            mul_inflight_q      <= '0;
            div_inflight_q      <= 1'b0;
            wr_ptr_q            <= '0;
            rd_ptr_q            <= '0;
            mul_issue_valid     <= 1'b0;
            mul_issue_uop       <= '0;
            mul_issue_rob_id    <= '0;
            mul_issue_thread_id <= '0;
            div_issue_valid     <= 1'b0;
            div_issue_uop       <= '0;
            div_issue_rob_id    <= '0;
            div_issue_thread_id <= '0;
        end else begin
            fifo_count_q    <= fifo_count_d;
            mul_inflight_q  <= mul_inflight_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            mul_issue_valid <= mul_grant;
            div_issue_valid <= div_grant;
            if (do_grant) begin
                rr_ptr_q <= gnt_idx + 2'd1;
            end
            if (div_grant) begin
                div_inflight_q <= 1'b1;
            end else if (div_push) begin
                div_inflight_q <= 1'b0;
            end
            if (mul_grant) begin
                mul_issue_uop       <= gnt_uop;
                mul_issue_rob_id    <= gnt_rob;
                mul_issue_thread_id <= gnt_idx;
            end
            if (div_grant) begin
                div_issue_uop       <= gnt_uop;
                div_issue_rob_id    <= gnt_rob;
                div_issue_thread_id <= gnt_idx;
            end
        end
    end

    // Same-cycle completions land mul first, then div, in consecutive slots.
    always_ff @(posedge clk) begin
        if (mul_push) begin
            fifo_mem[wr_ptr_q] <= {mul_result, mul_rob_id, mul_thread_id};
        end
        if (div_push) begin
            fifo_mem[div_wr_addr] <= {div_result, div_rob_id, div_thread_id};
        end
    end

    assign head         = fifo_mem[rd_ptr_q];
    assign wb_result    = wb_valid ? head[EW-1 -: UOP_W] : '0;
    assign wb_rob_id    = wb_valid ? head[ROB_W+1 -: ROB_W] : '0;
    assign wb_thread_id = wb_valid ? head[1:0] : '0;
    assign sched_busy   = (mul_inflight_q != '0) || div_inflight_q || (fifo_count_q != '0);

endmodule

// File: doc/vixen_muldiv_sched.md
Name: vixen_muldiv_sched

Overview:
Shared issue scheduler and writeback collector for the integer multiplier (pipelined, 4-cycle) and the iterative divider (10-20 cycles, one op in flight). Four hardware-thread requesters present uops with valid/ready. The block round-robin arbitrates, issues one uop per cycle to the correct unit, and collects completions into a credit-managed writeback FIFO. It sits between the per-thread issue queues and the mul/div execution units.

Parameters:
NUM_THREADS, 4, requester count; fixed at 4 to match the 2-bit thread_id.
WB_DEPTH, 4, writeback FIFO entries; power of 2, minimum 2.
UOP_W, 64, uop width.
ROB_W, 6, ROB id width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  4  per-thread request valid
req_ready  out  4  per-thread accept; one-hot or zero
req_is_div  in  4  per-thread: 1 = divide, 0 = multiply
req_uop  in  4*UOP_W  per-thread uop; thread i occupies bits [i*64 +: 64]
req_rob_id  in  4*ROB_W  per-thread ROB id
mul_issue_valid / mul_issue_uop / mul_issue_rob_id / mul_issue_thread_id  out  1/64/6/2  multiplier issue
mul_complete / mul_result / mul_rob_id / mul_thread_id  in  1/64/6/2  multiplier completion
div_issue_valid / div_issue_uop / div_issue_rob_id / div_issue_thread_id  out  1/64/6/2  divider issue
div_complete / div_result / div_rob_id / div_thread_id  in  1/64/6/2  divider completion
wb_valid  out  1  writeback FIFO head valid
wb_ready  in  1  consumer accepts head
wb_result / wb_rob_id / wb_thread_id  out  64/6/2  head entry
sched_busy  out  1  any op in flight or any entry buffered

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - all *_valid, req_ready and sched_busy = 0; data outputs = 0
  - rr_ptr = 0; mul_inflight = 0; div_inflight = 0; FIFO empty
- Credits:
  - credits = WB_DEPTH - (fifo_count + mul_inflight + div_inflight), computed combinationally.
  - Any issue requires credits >= 1. This guarantees a completion always has a FIFO slot, because the units cannot stall.
- Eligibility: thread i is eligible when req_valid[i] && credits >= 1, and either:
  - req_is_div[i] = 0, or
  - req_is_div[i] = 1 && div_inflight = 0.
- Ineligible requests never block eligible ones.
- Arbitration:
  - Round-robin over eligible threads, searching from rr_ptr upward with wrap.
  - At most one grant per cycle. req_ready = grant, combinational.
  - Transfer occurs on req_valid[i] && req_ready[i].
  - On a transfer, rr_ptr <= granted index + 1 (mod 4). With no transfer, rr_ptr holds.
- Issue:
  - The granted uop drives the mul_issue_* or div_issue_* outputs as registered outputs, valid for exactly 1 cycle, in the cycle after the grant.
  - thread_id = granted index.
  - The unused unit's issue_valid stays 0.
- In-flight tracking:
  - mul_inflight increments on a mul grant and decrements on mul_complete. A simultaneous increment and decrement nets to 0.
  - div_inflight is a 1-bit flag: set on a div grant, cleared on div_complete.
  - A div_complete with div_inflight = 0 is ignored.
- FIFO push:
  - mul_complete and div_complete in the same cycle push two entries, mul first, then div.
  - Push data comes from the unit's result, rob_id and thread_id.
- FIFO pop: occurs when wb_valid && wb_ready. A push and a pop in the same cycle are both honoured; the count changes by pushes - pops.
- FIFO ordering:
  - FIFO order is completion order, not issue order.
  - Read and write pointers wrap modulo WB_DEPTH.
- Full and empty:
  - Credits reaching 0 blocks all grants.
  - wb_valid = 0 when the FIFO is empty.
  - Overflow cannot occur. The bench asserts fifo_count <= WB_DEPTH.
- sched_busy = (mul_inflight != 0) || div_inflight || (fifo_count != 0).
- Reset mid-operation: all state clears immediately. In-flight unit results arriving after reset deassertion are dropped because their in-flight counters are 0, which requires the units to be reset on the same rst_n.
- Latency:
  - Request to unit issue: 1 cycle.
  - Unit complete to wb_valid: 1 cycle when the FIFO was empty.

Test Plan:
1. Threads 0-3 all request mul at once, wb_ready = 1, WB_DEPTH = 4. Required: grants in order 0,1,2,3 on consecutive cycles; mul_issue_thread_id sequence 0,1,2,3; rr_ptr returns to 0.
2. Thread 1 requests div (rob 5) and thread 2 requests div (rob 9). Required: thread 1 is granted; thread 2 stalls until cycle after div_complete; div_issue_rob_id is 5, then 9.
3. Thread 0 requests div while the divider is busy, and thread 3 requests mul. Required: thread 3 is granted immediately; thread 0 is not blocked beyond the divider's busy period.
4. wb_ready = 0 while 4 muls are issued. Required: the 5th mul request is held (req_ready = 0) with credits = 0. After one wb pop, exactly one new grant follows.
5. mul_complete (result 0x6, rob 3) and div_complete (result 0x2, rob 7) in the same cycle, FIFO empty. Required: wb pops rob 3, then rob 7; the count goes 0 → 2 → 1 → 0.
6. Assert rst_n low with 2 muls in flight and 1 FIFO entry. Required: all outputs are 0 immediately and sched_busy = 0. A first request after reset is granted to thread 0.
